// File: rtl/zion_clr_skid_slice_pkg.sv
// zion_skid_pkg: shared state encoding for the clear-able skid slice.
package zion_skid_pkg;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} skid_state_e;

endpackage

// File: rtl/zion_clr_skid_slice_dff.sv
// BcClrEnRanDff: enable DFF with synchronous clear to a parameterised value.
module BcClrEnRanDff #(
    parameter int unsigned WIDTH = 32,
    parameter logic [WIDTH-1:0] INI = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr)
            q <= INI;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/zion_clr_skid_slice.sv
// zion_clr_skid_slice: two-entry valid/ready skid slice with synchronous clear.
module zion_clr_skid_slice
    import zion_skid_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    skid_state_e state, stateNext;
    logic push, pop, flush, loadMain, loadSkid, selSkid;
    logic [WIDTH-1:0] skidQ, mainD;

    assign flush     = rst | clr;
    assign out_valid = state != EMPTY;
    assign in_ready  = state != FULL;
    assign count     = 2'(state);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign mainD     = selSkid ? skidQ : in_data;

    always_ff @(posedge clk) begin
        state <= flush ? EMPTY : stateNext;
    end

    always_comb begin
        stateNext = state;
        loadMain  = 1'b0;
        loadSkid  = 1'b0;
        selSkid   = 1'b0;
        unique case (state)
            EMPTY: begin
                stateNext = push ? ONE : EMPTY;
                loadMain  = push;
            end
            ONE: begin
                stateNext = (push & ~pop) ? FULL : (pop & ~push) ? EMPTY : ONE;
                loadMain  = push & pop;
                loadSkid  = push & ~pop;
            end
            FULL: begin
                stateNext = pop ? ONE : FULL;
                loadMain  = pop;
                selSkid   = 1'b1;
            end
            default: stateNext = EMPTY;
        endcase
    end

    // Clear wins over load inside the cells, so a flush voids any same-cycle load.
    BcClrEnRanDff #(.WIDTH(WIDTH), .INI(INI_DATA)) uMain (
        .clk(clk), .clr(flush), .en(loadMain), .d(mainD), .q(out_data)
    );

    BcClrEnRanDff #(.WIDTH(WIDTH), .INI(INI_DATA)) uSkid (
        .clk(clk), .clr(flush), .en(loadSkid), .d(in_data), .q(skidQ)
    );

endmodule

// File: tb/tb_zion_clr_skid_slice.sv
// tb_zion_clr_skid_slice: scoreboard-driven bench for the skid slice.
module tb_zion_clr_skid_slice;

    localparam logic [31:0] INI = 32'h1;

    logic clk = 1'b0, rst = 1'b0, clr = 1'b0;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [31:0] in_data = '0, out_data;
    logic [1:0] count;

    logic [31:0] sb[$];
    logic [31:0] lastData = INI;
    int total = 0, passed = 0;

    zion_clr_skid_slice #(.WIDTH(32), .INI_DATA(INI)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .count(count)
    );

    always #5 clk = ~clk;

    // One clock: drive, check outputs against the scoreboard mid-cycle, update the model.
    task automatic step(input logic iv, input logic [31:0] id, input logic ordy,
                        input logic c, input logic r, output logic acc);
        logic push, pop;
        logic [31:0] expData;
        in_valid = iv; in_data = id; out_ready = ordy; clr = c; rst = r;
        @(negedge clk);
        expData = sb.size() > 0 ? sb[0] : lastData;
        total++;
        if (count !== 2'(sb.size())) $display("FAIL count: got %0d want %0d", count, sb.size());
        else passed++;
        total++;
        if (out_valid !== (sb.size() != 0)) $display("FAIL out_valid: got %b want %b", out_valid, sb.size() != 0);
        else passed++;
        total++;
        if (in_ready !== (sb.size() != 2)) $display("FAIL in_ready: got %b want %b", in_ready, sb.size() != 2);
        else passed++;
        total++;
        if (out_data !== expData) $display("FAIL out_data: got %h want %h", out_data, expData);
        else passed++;
        push = iv && sb.size() < 2;
        pop = ordy && sb.size() > 0;
        if (pop) lastData = sb.pop_front();
        if (r || c) begin
            sb.delete();
            lastData = INI;
        end else if (push) sb.push_back(id);
        acc = push && !(r || c);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== INI || count !== 2'd0)
            $display("FAIL reset: got v=%b r=%b d=%h c=%0d want v=0 r=1 d=%h c=0",
                     out_valid, in_ready, out_data, count, INI);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream;
        logic acc;
        step(1, 32'hA5A5_0001, 1, 0, 0, acc);
        step(1, 32'hA5A5_0002, 1, 0, 0, acc);
        step(1, 32'hA5A5_0003, 1, 0, 0, acc);
        step(0, 0, 1, 0, 0, acc);
        step(0, 0, 1, 0, 0, acc);
    endtask

    task automatic test_backpressure;
        logic acc;
        step(1, 32'h11, 0, 0, 0, acc);
        step(1, 32'h22, 0, 0, 0, acc);
        step(1, 32'h33, 0, 0, 0, acc);
        total++;
        if (acc !== 1'b0 || count !== 2'd2 || in_ready !== 1'b0)
            $display("FAIL hold33: got acc=%b c=%0d r=%b want acc=0 c=2 r=0", acc, count, in_ready);
        else passed++;
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) step(1, 32'h33, 1, 0, 0, acc);
        total++;
        if (acc !== 1'b1) $display("FAIL accept33: got %b want 1", acc);
        else passed++;
        // Drain must be gapless: out_valid stays high until 33 has left.
        while (sb.size() > 0) begin
            total++;
            if (out_valid !== 1'b1) $display("FAIL drain_gap: got %b want 1", out_valid);
            else passed++;
            step(0, 0, 1, 0, 0, acc);
        end
        step(0, 0, 1, 0, 0, acc);
    endtask

    task automatic test_clear;
        logic acc;
        step(1, 32'h11, 0, 0, 0, acc);
        step(1, 32'h22, 0, 0, 0, acc);
        step(1, 32'h44, 0, 1, 0, acc);
        @(negedge clk);
        total++;
        if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== INI)
            $display("FAIL clear: got c=%0d v=%b d=%h want c=0 v=0 d=%h", count, out_valid, out_data, INI);
        else passed++;
        @(posedge clk);
        #1;
        step(0, 0, 1, 0, 0, acc);
    endtask

    task automatic test_reset_full;
        logic acc;
        step(1, 32'h55, 0, 0, 0, acc);
        step(1, 32'h66, 0, 0, 0, acc);
        step(0, 0, 1, 0, 1, acc);
        repeat (3) step(0, 0, 1, 0, 0, acc);
        total++;
        if (out_valid !== 1'b0 || out_data !== INI)
            $display("FAIL reset_full: got v=%b d=%h want v=0 d=%h", out_valid, out_data, INI);
        else passed++;
    endtask

    task automatic test_random;
        logic acc;
        int accepted = 0;
        logic [31:0] d = $urandom;
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), 0, 0, acc);
            if (acc) begin
                d = $urandom;
                accepted++;
            end
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, acc);
        total++;
        if (sb.size() != 0 || accepted < 1000)
            $display("FAIL random_drain: got left=%0d acc=%0d want left=0 acc>=1000", sb.size(), accepted);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_clear;
        test_reset_full;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
